// File: rtl/design_04_driver.sv
// design_04_driver
//   Initiator for the three-method design_04 core: start(sta,stb),
//   result(stc) and check(std). It takes one command from an upstream
//   valid/ready port, runs start -> result -> check on the core while
//   honouring each RDY_*, then presents the captured values with a pass
//   flag. It also keeps saturating pass/fail counters.
//
// Ports
//   CLK, RST_N             clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_a..cmd_d are the method
//                          arguments and cmd_expect is the expected result
//   start_sta_/start_stb_  start arguments; EN_start/RDY_start
//   result_stc_, result    result argument and return; RDY_result
//   check_std_, check      check argument and return; EN_check/RDY_check
//   rsp_valid/rsp_ready    response handshake; rsp_result, rsp_check,
//                          rsp_pass and rsp_timeout are the response fields
//   pass_count/fail_count  saturating response tallies
module design_04_driver #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] cmd_c,
    input  logic [WIDTH-1:0] cmd_d,
    input  logic [WIDTH-1:0] cmd_expect,
    output logic [WIDTH-1:0] start_sta_,
    output logic [WIDTH-1:0] start_stb_,
    output logic             EN_start,
    input  logic             RDY_start,
    output logic [WIDTH-1:0] result_stc_,
    input  logic [WIDTH-1:0] result,
    input  logic             RDY_result,
    output logic [WIDTH-1:0] check_std_,
    output logic             EN_check,
    input  logic [WIDTH-1:0] check,
    input  logic             RDY_check,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_check,
    output logic             rsp_pass,
    output logic             rsp_timeout,
    output logic [CNTW-1:0]  pass_count,
    output logic [CNTW-1:0]  fail_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_RESULT = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // The wait counter only has to count up to TIMEOUT-1: the TIMEOUT-th
    // low cycle is the abort cycle itself.
    localparam int            WCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CMAX = {CNTW{1'b1}};

    logic [2:0]       state;
    logic [WCW-1:0]   wcnt;
    logic [WIDTH-1:0] exp_q;
    logic             cur_rdy;
    logic             waiting;
    logic             in_wait;
    logic             expired;

    always_comb begin
        cmd_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        EN_start  = (state == S_START) & RDY_start;
        EN_check  = (state == S_CHECK) & RDY_check;
        waiting   = 1'b0;
        cur_rdy   = 1'b1;
        case (state)
            S_START:  begin waiting = 1'b1; cur_rdy = RDY_start;  end
            S_RESULT: begin waiting = 1'b1; cur_rdy = RDY_result; end
            S_CHECK:  begin waiting = 1'b1; cur_rdy = RDY_check;  end
            default:  ;
        endcase
        in_wait = waiting & ~cur_rdy;
        expired = in_wait & (wcnt == WLAST);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            exp_q       <= '0;
            start_sta_  <= '0;
            start_stb_  <= '0;
            result_stc_ <= '0;
            check_std_  <= '0;
            rsp_result  <= '0;
            rsp_check   <= '0;
            rsp_pass    <= 1'b0;
            rsp_timeout <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        start_sta_  <= cmd_a;
                        start_stb_  <= cmd_b;
                        result_stc_ <= cmd_c;
                        check_std_  <= cmd_d;
                        exp_q       <= cmd_expect;
                        // Fields a timeout leaves uncaptured must read 0.
                        rsp_result  <= '0;
                        rsp_check   <= '0;
                        rsp_pass    <= 1'b0;
                        rsp_timeout <= 1'b0;
                        wcnt        <= '0;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    if (RDY_start) begin
                        wcnt  <= '0;
                        state <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (RDY_result) begin
                        rsp_result <= result;
                        wcnt       <= '0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (RDY_check) begin
                        rsp_check <= check;
                        rsp_pass  <= (rsp_result == exp_q);
                        wcnt      <= '0;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        // rsp_pass is already 0 on a timeout, so it alone
                        // selects the counter.
                        if (rsp_pass) begin
                            if (pass_count != CMAX) pass_count <= pass_count + CNTW'(1);
                        end else begin
                            if (fail_count != CMAX) fail_count <= fail_count + CNTW'(1);
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // in_wait implies the state's RDY is low, so the case above made
            // no transition this cycle and these writes cannot collide.
            if (expired) begin
                rsp_timeout <= 1'b1;
                rsp_pass    <= 1'b0;
                wcnt        <= '0;
                state       <= S_RESP;
            end else if (in_wait) begin
                wcnt <= wcnt + WCW'(1);
            end
        end
    end

endmodule
